// File: rtl/tag_fifo_wr_arb.sv
// Round-robin write arbiter sharing one tag FIFO write port among NUM_REQ lanes.
// A granted lane keeps the port until its last beat (or MAX_BEATS) so bursts never interleave.
module tag_fifo_wr_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_cs_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          err_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_BEATS - 1);
  localparam logic [PTR_W:0]   NUM_EXT   = (PTR_W + 1)'(NUM_REQ);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state, state_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic               err_nxt;

  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     scan;
  logic               found;
  logic               g_valid;
  logic               g_last;
  logic               accept;
  logic               cap_hit;

  // Decode the one-hot grant into a lane index and AND-OR mux its signals.
  always_comb begin
    gidx        = '0;
    g_valid     = 1'b0;
    g_last      = 1'b0;
    fifo_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx        = PTR_W'(i);
        g_valid     = req_valid_i[i];
        g_last      = req_last_i[i];
        fifo_data_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Wrap-around search starting at ptr; first valid lane wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (scan >= NUM_EXT) scan = scan - NUM_EXT;
      if (!found && req_valid_i[scan[PTR_W-1:0]]) begin
        found = 1'b1;
        win   = scan[PTR_W-1:0];
      end
    end
  end

  assign req_ready_o  = grant & {NUM_REQ{~fifo_full_i}};
  assign accept       = (state == LOCKED) & g_valid & ~fifo_full_i;
  assign fifo_wr_cs_o = accept;
  assign fifo_wr_en_o = accept;
  assign grant_o      = grant;
  assign cap_hit      = (beat_cnt == CNT_LAST);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;
    err_nxt      = err_o;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = LOCKED;
          grant_nxt    = NUM_REQ'(1) << win;
          beat_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (g_last || cap_hit) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            ptr_nxt   = (gidx == LAST_LANE) ? '0 : gidx + 1'b1;
            // Forced release without a last beat marks a malformed burst.
            if (cap_hit && !g_last) err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      err_o    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_tag_fifo_wr_arb.sv
// Scoreboard bench for tag_fifo_wr_arb: lane sources replay queued bursts, expected FIFO
// words are queued in the order arbitration must produce them.
module tb_tag_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid_i;
  logic [N-1:0]      req_last_i;
  logic [N*DW-1:0]   req_data_i;
  logic [N-1:0]      req_ready_o;
  logic              fifo_full_i;
  logic              fifo_wr_cs_o;
  logic              fifo_wr_en_o;
  logic [DW-1:0]     fifo_data_o;
  logic [N-1:0]      grant_o;
  logic              err_o;

  always #5 clk = ~clk;

  tag_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_last_i   (req_last_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .fifo_full_i  (fifo_full_i),
    .fifo_wr_cs_o (fifo_wr_cs_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .grant_o      (grant_o),
    .err_o        (err_o)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  int            uid      = 0;
  logic [DW-1:0] sb[$];
  logic [DW:0]   lane_mem [N][64];
  int            head [N];
  int            tail [N];
  logic [N-1:0]  hs;
  logic          full_nxt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_burst(input int lane, input int nbeats, input bit with_last);
    logic [DW-1:0] d;
    for (int b = 0; b < nbeats; b++) begin
      d = {8'hA0, 8'(lane), 16'(uid)};
      uid++;
      lane_mem[lane][tail[lane]] = {(with_last && (b == nbeats - 1)), d};
      tail[lane]++;
      sb.push_back(d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) head[i]++;
      if (head[i] < tail[i]) begin
        req_valid_i[i]          = 1'b1;
        req_last_i[i]           = lane_mem[i][head[i]][DW];
        req_data_i[i*DW +: DW]  = lane_mem[i][head[i]][DW-1:0];
      end else begin
        req_valid_i[i]          = 1'b0;
        req_last_i[i]           = 1'b0;
        req_data_i[i*DW +: DW]  = '0;
      end
    end
    fifo_full_i = full_nxt;
    @(negedge clk);
    hs = req_valid_i & req_ready_o;
    check_eq("cs_eq_en", 64'(fifo_wr_cs_o), 64'(fifo_wr_en_o));
    if (fifo_wr_en_o) begin
      if (sb.size() == 0) check_eq("unexpected_write", 64'(fifo_wr_en_o), 64'd0);
      else                check_eq("fifo_data", 64'(fifo_data_o), 64'(sb.pop_front()));
    end
    if (grant_o == '0) check_eq("idle_data_zero", 64'(fifo_data_o), 64'd0);
  endtask

  initial begin
    logic [N-1:0] eg;
    int           seq [5];
    rst         = 1'b0;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    fifo_full_i = 1'b0;
    full_nxt    = 1'b0;
    hs          = '0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end

    // Reset state
    step(); step();
    check_eq("rst_grant", 64'(grant_o), 64'd0);
    check_eq("rst_ready", 64'(req_ready_o), 64'd0);
    check_eq("rst_cs", 64'(fifo_wr_cs_o), 64'd0);
    check_eq("rst_en", 64'(fifo_wr_en_o), 64'd0);
    check_eq("rst_data", 64'(fifo_data_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("idle_grant", 64'(grant_o), 64'd0);
      check_eq("idle_wr", 64'(fifo_wr_en_o), 64'd0);
    end

    // Lane 1 three-beat burst
    add_burst(1, 3, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("b3_grant", 64'(grant_o), (c >= 1 && c <= 3) ? 64'h2 : 64'h0);
      check_eq("b3_wr", 64'(fifo_wr_en_o), (c >= 1 && c <= 3) ? 64'd1 : 64'd0);
    end

    // ptr now 2: lanes 0 and 2 together must serve lane 2 first
    add_burst(2, 1, 1'b1);
    add_burst(0, 1, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step();
      eg = (c == 1) ? 4'b0100 : (c == 3) ? 4'b0001 : 4'b0000;
      check_eq("ptr_grant", 64'(grant_o), 64'(eg));
    end

    rst = 1'b0;
    step();
    rst = 1'b1;

    // Round robin from ptr=0 with single-beat bursts
    add_burst(0, 1, 1'b1);
    add_burst(1, 1, 1'b1);
    add_burst(2, 1, 1'b1);
    add_burst(3, 1, 1'b1);
    add_burst(0, 1, 1'b1);
    seq = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 11; c++) begin
      step();
      eg = ((c % 2) == 1 && c <= 9) ? (4'b0001 << seq[c/2]) : 4'b0000;
      check_eq("rr_grant", 64'(grant_o), 64'(eg));
    end

    // Lane 0 mid-burst while lane 2 requests
    add_burst(0, 4, 1'b1);
    step();
    check_eq("ni_grant0", 64'(grant_o), 64'd0);
    add_burst(2, 1, 1'b1);
    for (int c = 1; c < 8; c++) begin
      step();
      eg = (c <= 4) ? 4'b0001 : (c == 6) ? 4'b0100 : 4'b0000;
      check_eq("ni_grant", 64'(grant_o), 64'(eg));
      if (c <= 4) check_eq("ni_ready2", 64'(req_ready_o[2]), 64'd0);
    end

    // Lane 3 burst with full for 5 cycles, then full on the last beat
    add_burst(3, 4, 1'b1);
    for (int c = 0; c < 12; c++) begin
      full_nxt = ((c >= 2 && c <= 6) || c == 9);
      step();
      check_eq("bp_grant", 64'(grant_o), (c >= 1 && c <= 10) ? 64'h8 : 64'h0);
      check_eq("bp_wr", 64'(fifo_wr_en_o), (c == 1 || c == 7 || c == 8 || c == 10) ? 64'd1 : 64'd0);
      check_eq("bp_ready3", 64'(req_ready_o[3]), ((c >= 1 && c <= 10) && !full_nxt) ? 64'd1 : 64'd0);
    end
    full_nxt = 1'b0;

    // MAX_BEATS overflow on lane 0
    add_burst(0, MB, 1'b0);
    for (int c = 0; c < MB + 4; c++) begin
      step();
      check_eq("ovf_grant", 64'(grant_o), (c >= 1 && c <= MB) ? 64'h1 : 64'h0);
      check_eq("ovf_wr", 64'(fifo_wr_en_o), (c >= 1 && c <= MB) ? 64'd1 : 64'd0);
      check_eq("ovf_err", 64'(err_o), (c >= MB + 1) ? 64'd1 : 64'd0);
    end
    rst = 1'b0;
    step();
    check_eq("err_cleared", 64'(err_o), 64'd0);
    rst = 1'b1;
    step();

    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
